// File: rtl/ulx3s_clk_sequencer.sv
// Power-up clock sequencer: filters PLL lock, releases per-channel domain
// resets in a staggered order and generates per-channel clock-enable strobes.
module ulx3s_clk_sequencer #(
  parameter int CHANNELS    = 2,
  parameter int DIVW        = 8,
  parameter int LOCK_FILTER = 16,
  parameter int STAGGER     = 4
) (
  input  logic                     clkin,
  input  logic                     resetn,
  input  logic                     pll_locked,
  input  logic [CHANNELS*DIVW-1:0] div,
  input  logic                     clear_lost,
  output logic [CHANNELS-1:0]      ce,
  output logic [CHANNELS-1:0]      rst_out,
  output logic                     ready,
  output logic                     lock_lost
);

  localparam int FW      = (LOCK_FILTER > 2) ? $clog2(LOCK_FILTER) : 1;
  localparam int REL_MAX = (CHANNELS > 1) ? (CHANNELS - 1) * STAGGER - 1 : 0;
  localparam int RELW    = (REL_MAX > 1) ? $clog2(REL_MAX + 1) : 1;
  localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILTER - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    FILTER,
    RELEASE,
    RUN
  } state_t;

  state_t              state;
  logic                sync1;
  logic                lk;
  logic [FW-1:0]       filt_cnt;
  logic [RELW-1:0]     rel_cnt;
  logic [CHANNELS-1:0] rel_hit;
  logic [CHANNELS-1:0] rst_nxt;

  always_ff @(posedge clkin) begin
    if (!resetn) begin
      sync1 <= 1'b0;
      lk    <= 1'b0;
    end else begin
      sync1 <= pll_locked;
      lk    <= sync1;
    end
  end

  // Channel i (i>0) is released i*STAGGER cycles after channel 0.
  always_comb begin
    rel_hit = '0;
    for (int i = 1; i < CHANNELS; i++) begin
      rel_hit[i] = (rel_cnt == RELW'(i * STAGGER - 1));
    end
  end

  // Next-cycle reset vector; the dividers need it to strobe on the release edge.
  always_comb begin
    rst_nxt = '1;
    if (resetn) begin
      case (state)
        FILTER: begin
          if (lk && (filt_cnt == FILT_LAST)) begin
            rst_nxt[0] = 1'b0;
          end
        end
        RELEASE: begin
          if (lk) begin
            rst_nxt = rst_out & ~rel_hit;
          end
        end
        RUN: begin
          if (lk) begin
            rst_nxt = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clkin) begin
    if (!resetn) begin
      state     <= WAIT_LOCK;
      filt_cnt  <= '0;
      rel_cnt   <= '0;
      rst_out   <= '1;
      ready     <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      rst_out <= rst_nxt;
      ready   <= ~|rst_nxt;

      // A loss seen in RUN beats a simultaneous clear.
      if ((state == RUN) && !lk) begin
        lock_lost <= 1'b1;
      end else if (clear_lost) begin
        lock_lost <= 1'b0;
      end

      case (state)
        WAIT_LOCK: begin
          filt_cnt <= '0;
          rel_cnt  <= '0;
          if (lk) begin
            state <= FILTER;
          end
        end
        FILTER: begin
          if (!lk) begin
            state    <= WAIT_LOCK;
            filt_cnt <= '0;
          end else if (filt_cnt == FILT_LAST) begin
            filt_cnt <= '0;
            rel_cnt  <= '0;
            state    <= (~|rst_nxt) ? RUN : RELEASE;
          end else begin
            filt_cnt <= filt_cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (!lk) begin
            state <= WAIT_LOCK;
          end else if (~|rst_nxt) begin
            state <= RUN;
          end else begin
            rel_cnt <= rel_cnt + 1'b1;
          end
        end
        RUN: begin
          if (!lk) begin
            state <= WAIT_LOCK;
          end
        end
        default: state <= WAIT_LOCK;
      endcase
    end
  end

  // ce is high in exactly the cycles where the divider count reads zero.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_div
    logic [DIVW-1:0] div_cnt;
    logic [DIVW-1:0] div_val;

    assign div_val = div[g*DIVW +: DIVW];

    always_ff @(posedge clkin) begin
      if (!resetn) begin
        div_cnt <= '0;
        ce[g]   <= 1'b0;
      end else if (rst_nxt[g]) begin
        div_cnt <= div_val;
        ce[g]   <= 1'b0;
      end else if (rst_out[g] || (div_cnt == '0)) begin
        div_cnt <= div_val;
        ce[g]   <= (div_val == '0);
      end else begin
        div_cnt <= div_cnt - 1'b1;
        ce[g]   <= (div_cnt == DIVW'(1));
      end
    end
  end

endmodule

// File: tb/tb_ulx3s_clk_sequencer.sv
// Directed vector bench for ulx3s_clk_sequencer with default parameters,
// channel 0 divide 0 and channel 1 divide driven per vector.
module tb_ulx3s_clk_sequencer;

  logic        clkin = 1'b0;
  logic        resetn = 1'b0;
  logic        pll_locked = 1'b0;
  logic        clear_lost = 1'b0;
  logic [15:0] div = 16'h0300;
  logic [1:0]  ce;
  logic [1:0]  rst_out;
  logic        ready;
  logic        lock_lost;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clkin = ~clkin;

  ulx3s_clk_sequencer dut (
    .clkin      (clkin),
    .resetn     (resetn),
    .pll_locked (pll_locked),
    .div        (div),
    .clear_lost (clear_lost),
    .ce         (ce),
    .rst_out    (rst_out),
    .ready      (ready),
    .lock_lost  (lock_lost)
  );

  typedef struct {
    string      name;
    logic       rstn;
    logic       pll;
    logic       clr;
    logic [7:0] div1;
    int         cyc;
    logic [1:0] e_rst;
    logic [1:0] e_ce;
    logic [1:0] ce_chk;
    logic       e_rdy;
    logic       e_lost;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic rstn, input logic pll,
                     input logic clr, input logic [7:0] d1, input int cyc,
                     input logic [1:0] e_rst, input logic [1:0] e_ce,
                     input logic [1:0] ce_chk, input logic e_rdy,
                     input logic e_lost);
    vec_t v;
    v.name = name; v.rstn = rstn; v.pll = pll; v.clr = clr; v.div1 = d1;
    v.cyc = cyc; v.e_rst = e_rst; v.e_ce = e_ce; v.ce_chk = ce_chk;
    v.e_rdy = e_rdy; v.e_lost = e_lost;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rstn, input logic pll,
                               input logic clr, input logic [7:0] d1,
                               input int cyc);
    resetn     = rstn;
    pll_locked = pll;
    clear_lost = clr;
    div        = {d1, 8'd0};
    repeat (cyc) @(negedge clkin);
  endtask

  task automatic checkOutput(input string name, input logic [1:0] e_rst,
                             input logic [1:0] e_ce, input logic [1:0] ce_chk,
                             input logic e_rdy, input logic e_lost);
    check({name, ".rst_out"}, {6'd0, rst_out}, {6'd0, e_rst});
    if (ce_chk != 2'b00) begin
      check({name, ".ce"}, {6'd0, ce & ce_chk}, {6'd0, e_ce & ce_chk});
    end
    check({name, ".ready"}, {7'd0, ready}, {7'd0, e_rdy});
    check({name, ".lock_lost"}, {7'd0, lock_lost}, {7'd0, e_lost});
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cnt;

    // name, rstn, pll, clr, div1, cycles, rst, ce, ce_chk, ready, lost
    add("reset",         0, 0, 0, 8'd3, 2,  2'b11, 2'b00, 2'b11, 0, 0);
    add("idle",          1, 0, 0, 8'd3, 8,  2'b11, 2'b00, 2'b11, 0, 0);
    add("filter",        1, 1, 0, 8'd3, 18, 2'b11, 2'b00, 2'b11, 0, 0);
    add("rel_ch0",       1, 1, 0, 8'd3, 1,  2'b10, 2'b01, 2'b11, 0, 0);
    add("stagger",       1, 1, 0, 8'd3, 3,  2'b10, 2'b01, 2'b11, 0, 0);
    add("rel_ch1",       1, 1, 0, 8'd3, 1,  2'b00, 2'b01, 2'b11, 1, 0);
    add("ce1_first",     1, 1, 0, 8'd3, 3,  2'b00, 2'b11, 2'b11, 1, 0);
    add("ce1_after",     1, 1, 0, 8'd3, 1,  2'b00, 2'b01, 2'b11, 1, 0);
    add("ce1_period4",   1, 1, 0, 8'd3, 3,  2'b00, 2'b11, 2'b11, 1, 0);
    add("cnt_at_2",      1, 1, 0, 8'd3, 2,  2'b00, 2'b01, 2'b11, 1, 0);
    add("div7_a",        1, 1, 0, 8'd7, 1,  2'b00, 2'b01, 2'b11, 1, 0);
    add("div7_old_run",  1, 1, 0, 8'd7, 1,  2'b00, 2'b11, 2'b11, 1, 0);
    add("div7_reload",   1, 1, 0, 8'd7, 1,  2'b00, 2'b01, 2'b11, 1, 0);
    add("div7_gap",      1, 1, 0, 8'd7, 6,  2'b00, 2'b01, 2'b11, 1, 0);
    add("div7_strobe",   1, 1, 0, 8'd7, 1,  2'b00, 2'b11, 2'b11, 1, 0);
    add("div7_period8",  1, 1, 0, 8'd7, 8,  2'b00, 2'b11, 2'b11, 1, 0);
    add("loss_sync",     1, 0, 0, 8'd7, 2,  2'b00, 2'b01, 2'b11, 1, 0);
    add("loss",          1, 0, 0, 8'd7, 1,  2'b11, 2'b00, 2'b11, 0, 1);
    add("relock_filt",   1, 1, 0, 8'd7, 18, 2'b11, 2'b00, 2'b11, 0, 1);
    add("relock_ch0",    1, 1, 0, 8'd7, 1,  2'b10, 2'b01, 2'b11, 0, 1);
    add("relock_run",    1, 1, 0, 8'd7, 4,  2'b00, 2'b01, 2'b11, 1, 1);
    add("run_reset",     0, 1, 0, 8'd7, 1,  2'b11, 2'b00, 2'b11, 0, 0);
    add("post_rst_filt", 1, 1, 0, 8'd7, 18, 2'b11, 2'b00, 2'b11, 0, 0);
    add("post_rst_ch0",  1, 1, 0, 8'd7, 1,  2'b10, 2'b01, 2'b11, 0, 0);
    add("post_rst_run",  1, 1, 0, 8'd7, 4,  2'b00, 2'b01, 2'b11, 1, 0);
    add("clr_loss_sync", 1, 0, 0, 8'd7, 2,  2'b00, 2'b01, 2'b01, 1, 0);
    add("clr_and_loss",  1, 0, 1, 8'd7, 1,  2'b11, 2'b00, 2'b11, 0, 1);
    add("lost_sticky",   1, 0, 0, 8'd7, 3,  2'b11, 2'b00, 2'b11, 0, 1);
    add("clear",         1, 0, 1, 8'd7, 1,  2'b11, 2'b00, 2'b11, 0, 0);
    add("pulse10",       1, 1, 0, 8'd7, 10, 2'b11, 2'b00, 2'b11, 0, 0);
    add("pulse10_drop",  1, 0, 0, 8'd7, 20, 2'b11, 2'b00, 2'b11, 0, 0);
    add("pulse16",       1, 1, 0, 8'd7, 16, 2'b11, 2'b00, 2'b11, 0, 0);
    add("pulse16_drop",  1, 0, 0, 8'd7, 3,  2'b11, 2'b00, 2'b11, 0, 0);
    add("refilt",        1, 1, 0, 8'd7, 18, 2'b11, 2'b00, 2'b11, 0, 0);
    add("refilt_ch0",    1, 1, 0, 8'd7, 1,  2'b10, 2'b01, 2'b11, 0, 0);
    add("rel_loss_sync", 1, 0, 0, 8'd7, 2,  2'b10, 2'b01, 2'b11, 0, 0);
    add("rel_loss",      1, 0, 0, 8'd7, 1,  2'b11, 2'b00, 2'b11, 0, 0);
    add("rel_relock",    1, 1, 0, 8'd7, 18, 2'b11, 2'b00, 2'b11, 0, 0);
    add("rel_relock_c0", 1, 1, 0, 8'd7, 1,  2'b10, 2'b01, 2'b11, 0, 0);
    add("mid_rel_reset", 0, 1, 0, 8'd7, 1,  2'b11, 2'b00, 2'b11, 0, 0);
    add("final_filt",    1, 1, 0, 8'd7, 18, 2'b11, 2'b00, 2'b11, 0, 0);
    add("final_ch0",     1, 1, 0, 8'd7, 1,  2'b10, 2'b01, 2'b11, 0, 0);
    add("final_run",     1, 1, 0, 8'd7, 4,  2'b00, 2'b01, 2'b11, 1, 0);

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].rstn, vecs[k].pll, vecs[k].clr, vecs[k].div1,
                    vecs[k].cyc);
      checkOutput(vecs[k].name, vecs[k].e_rst, vecs[k].e_ce, vecs[k].ce_chk,
                  vecs[k].e_rdy, vecs[k].e_lost);
    end

    // Channel 1 count is 7 here; div 0 takes over at the next reload.
    applyStimulus(1, 1, 0, 8'd0, 0);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clkin);
      check($sformatf("div0_ce1_cyc%0d", i), {7'd0, ce[1]},
            {7'd0, (i >= 7) ? 1'b1 : 1'b0});
    end

    // Loss from RUN, then a bounded wait for the full relock sequence.
    applyStimulus(1, 0, 0, 8'd0, 3);
    checkOutput("loss2", 2'b11, 2'b00, 2'b11, 0, 1);
    applyStimulus(1, 1, 0, 8'd0, 0);
    cnt = 0;
    while (!ready && cnt < 40) begin
      @(negedge clkin);
      cnt++;
    end
    check("relock_latency", 8'(cnt), 8'd23);
    checkOutput("relock2_run", 2'b00, 2'b11, 2'b11, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
